lcg_stream_checker: RTL and testbench
=====================================

// Module: lcg_stream_checker
// PURPOSE
//  Receive-side checker for the LCG output stream x(i+1) = (a*x(i) + b) mod 2^W.
//  Self-seeds from the incoming samples and locks after LOCK_N consecutive correct
//  predictions. Counts prediction errors and drops lock after LOSS_N consecutive misses.
//  Sits on the consumer end of the LCG/dual-CLCG output as an on-line integrity monitor.
// PARAMETERS
//  W       4   sample width; modulus is 2^W (implemented by truncation)
//  LOCK_N  3   consecutive matches required to declare lock (>=1)
//  LOSS_N  2   consecutive mismatches in LOCKED that force resync (>=1)
//  CW      8   width of err_cnt / period counter
// PORTS
//  clk1       in   1     single clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  start      in   1     enable; low returns to IDLE
//  a          in   W     multiplier, sampled each cycle (held stable while start=1)
//  b          in   W     increment, sampled each cycle (held stable while start=1)
//  in_valid   in   1     in_data carries a stream sample this cycle
//  in_data    in   W     received LCG sample
//  expected   out  W     registered prediction for the next sample
//  locked     out  1     high in LOCKED state
//  err_pulse  out  1     one-cycle pulse per mismatch while LOCKED
//  err_cnt    out  CW    saturating mismatch count since last reset
//  lost       out  1     sticky: lock was lost at least once; cleared only by reset
//  period     out  CW    (LCG_CHK_PERIOD_EN only) measured sequence period
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; expected=0, locked=0, err_pulse=0, err_cnt=0, lost=0, period=0.
//  - Samples are accepted only on edges where in_valid=1 and state!=IDLE; all outputs are registered,
//    and the result for a sample accepted at edge k is visible after edge k (1-cycle latency).
//  - Next-value arithmetic: full product a*x is 2W bits; add b; keep low W bits.
//  - IDLE: start=1 -> SEED. Counters are held, not cleared.
//  - SEED: the first accepted sample x -> expected=f(x); match_cnt=0 -> SYNC.
//  - SYNC: an accepted sample equal to expected -> match_cnt+1, expected=f(sample).
//    When match_cnt reaches LOCK_N, go to LOCKED and set locked=1 on that same edge.
//    A mismatch reseeds: expected=f(sample), match_cnt=0. No err_pulse is issued in SYNC.
//  - LOCKED: each accepted sample is compared with expected.
//    On a match, clear miss_cnt.
//    On a mismatch, err_pulse=1, err_cnt+1 (saturates at 2^CW-1), miss_cnt+1.
//    In both cases expected=f(expected): the reference free-runs and is never reseeded from bad data.
//    When miss_cnt reaches LOSS_N: locked=0, lost=1, -> SYNC with expected=f(current sample)
//    and match_cnt=0.
//  - in_valid=0: state, expected and all counters hold; err_pulse=0.
//  - start=0 in any state (including mid-lock): -> IDLE on the next edge; locked=0.
//    err_cnt, lost and period are kept.
//  - start and a mismatch on the same edge: start=0 wins; no err_pulse, err_cnt unchanged.
//  - a/b changed while start=1 is unsupported; the result is mismatches and eventual resync.
// CONFIGURATION
//  LCG_CHK_PERIOD_EN defined:
//    - On entry to LOCKED, latch ref=expected and clear pcnt.
//    - Each accepted LOCKED sample increments pcnt.
//    - When the sample equals ref, period=pcnt+1 and pcnt restarts. pcnt saturates at 2^CW-1.
//    - period resets to 0 and holds its value across IDLE.
//  Not defined: the period port and its logic are absent; all other behaviour is identical.
// TESTING
//  1 W=4, a=5, b=1; stream 3,0,1,6,15,12,... one sample per cycle, start=1 -> locked rises
//    on the edge accepting the 4th sample (6); err_cnt=0.
//  2 Locked stream, inject 9 in place of 13 once -> a single err_pulse, err_cnt=1, locked stays 1,
//    and the next sample 2 matches.
//  3 Locked stream, two consecutive wrong samples -> err_cnt+=2, locked=0, lost=1,
//    relock after LOCK_N further correct samples.
//  4 in_valid toggled 1/0 every cycle on the scenario-1 stream -> same lock point counted in
//    samples; no err_pulse.
//  5 start=0 while locked, then start=1 -> IDLE, locked=0, err_cnt retained, reseed and relock.
//    Assert rst_n=0 mid-stream -> all outputs 0 immediately.
//  6 LCG_CHK_PERIOD_EN, a=5, b=1, seed 3 -> period=16 after one full cycle.
//    a=1, b=2 -> period=8.

Source files
------------

// File: rtl/lcg_stream_checker_if.sv
// Stream/status bundle between an LCG sample source and lcg_stream_checker.
// The period field exists only when LCG_CHK_PERIOD_EN is defined.
interface lcg_stream_checker_if #(
    parameter int W  = 4,
    parameter int CW = 8
);
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [W-1:0]  expected;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_cnt;
    logic          lost;
`ifdef LCG_CHK_PERIOD_EN
    logic [CW-1:0] period;
`endif

    modport master (
        output start, a, b, in_valid, in_data,
`ifdef LCG_CHK_PERIOD_EN
        input  period,
`endif
        input  expected, locked, err_pulse, err_cnt, lost
    );

    modport slave (
        input  start, a, b, in_valid, in_data,
`ifdef LCG_CHK_PERIOD_EN
        output period,
`endif
        output expected, locked, err_pulse, err_cnt, lost
    );
endinterface

// File: rtl/lcg_stream_checker.sv
// On-line integrity monitor for an LCG stream x' = (a*x + b) mod 2^W: self-seeds, locks, counts misses.
// 1-cycle latency, all outputs registered; no backpressure. Optional period meter: LCG_CHK_PERIOD_EN.
module lcg_stream_checker #(
    parameter int W      = 4,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 2,
    parameter int CW     = 8
) (
    input  logic                clk1,
    input  logic                rst_n,
    lcg_stream_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_N + 1);
    localparam int SW = $clog2(LOSS_N + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_N - 1);
    localparam logic [SW-1:0] LOSS_LAST = SW'(LOSS_N - 1);

    typedef enum logic [1:0] {IDLE, SEED, SYNC, LOCKED} state_t;

    state_t        r_state;
    logic [W-1:0]  r_expected;
    logic          r_locked;
    logic          r_err_pulse;
    logic [CW-1:0] r_err_cnt;
    logic          r_lost;
    logic [MW-1:0] r_match_cnt;
    logic [SW-1:0] r_miss_cnt;
`ifdef LCG_CHK_PERIOD_EN
    logic [W-1:0]  r_ref;
    logic [CW-1:0] r_pcnt;
    logic [CW-1:0] r_period;
`endif

    // Low W bits of the 2W-bit product depend only on the operands' low W bits,
    // so a W-bit multiply/add yields the truncated next value directly.
    logic [W-1:0] w_f_in;
    logic [W-1:0] w_f_exp;
    logic         w_hit;

    assign w_f_in  = bus.a * bus.in_data  + bus.b;
    assign w_f_exp = bus.a * r_expected   + bus.b;
    assign w_hit   = (bus.in_data == r_expected);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_expected  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_lost      <= 1'b0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
`ifdef LCG_CHK_PERIOD_EN
            r_ref       <= '0;
            r_pcnt      <= '0;
            r_period    <= '0;
`endif
        end else begin
            r_err_pulse <= 1'b0;
            if (!bus.start) begin
                r_state  <= IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= SEED;
                    SEED: if (bus.in_valid) begin
                        r_expected  <= w_f_in;
                        r_match_cnt <= '0;
                        r_state     <= SYNC;
                    end
                    SYNC: if (bus.in_valid) begin
                        r_expected <= w_f_in;
                        if (!w_hit) begin
                            r_match_cnt <= '0;
                        end else if (r_match_cnt == LOCK_LAST) begin
                            r_state    <= LOCKED;
                            r_locked   <= 1'b1;
                            r_miss_cnt <= '0;
`ifdef LCG_CHK_PERIOD_EN
                            r_ref      <= bus.in_data;
                            r_pcnt     <= '0;
`endif
                        end else begin
                            r_match_cnt <= r_match_cnt + 1'b1;
                        end
                    end
                    LOCKED: if (bus.in_valid) begin
`ifdef LCG_CHK_PERIOD_EN
                        if (bus.in_data == r_ref) begin
                            r_period <= (r_pcnt == '1) ? r_pcnt : r_pcnt + 1'b1;
                            r_pcnt   <= '0;
                        end else if (r_pcnt != '1) begin
                            r_pcnt <= r_pcnt + 1'b1;
                        end
`endif
                        if (w_hit) begin
                            r_miss_cnt <= '0;
                            r_expected <= w_f_exp;
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (r_err_cnt != '1)
                                r_err_cnt <= r_err_cnt + 1'b1;
                            // Reference free-runs until lock is lost, then reseeds from the live sample.
                            if (r_miss_cnt == LOSS_LAST) begin
                                r_locked    <= 1'b0;
                                r_lost      <= 1'b1;
                                r_state     <= SYNC;
                                r_expected  <= w_f_in;
                                r_match_cnt <= '0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + 1'b1;
                                r_expected <= w_f_exp;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.expected  = r_expected;
    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.lost      = r_lost;
`ifdef LCG_CHK_PERIOD_EN
    assign bus.period    = r_period;
`endif
endmodule

// File: tb/tb_lcg_stream_checker.sv
// Directed bench for lcg_stream_checker: vector table plus hand sequences for saturation, async reset and period.
module tb_lcg_stream_checker;
    logic clk1  = 1'b0;
    logic rst_n = 1'b0;

    lcg_stream_checker_if #(.W(4), .CW(8)) bus ();

    lcg_stream_checker dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic       start;
        logic [3:0] a;
        logic [3:0] b;
        logic       val;
        logic [3:0] data;
        logic [3:0] e_exp;
        logic       e_lk;
        logic       e_pl;
        logic [7:0] e_cnt;
        logic       e_lost;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic st, input logic [3:0] a, input logic [3:0] b,
                       input logic v, input logic [3:0] d, input logic [3:0] ee,
                       input logic el, input logic ep, input logic [7:0] ec, input logic elost);
        vec_t t;
        t.start = st; t.a = a; t.b = b; t.val = v; t.data = d;
        t.e_exp = ee; t.e_lk = el; t.e_pl = ep; t.e_cnt = ec; t.e_lost = elost;
        vt.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nf(input logic [3:0] x, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = a * x + b;
        return p[3:0];
    endfunction

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic [3:0] d);
        bus.start = st; bus.in_valid = v; bus.in_data = d;
    endtask

    initial begin
        logic [3:0] e;
        logic [7:0] cnt;
`ifdef LCG_CHK_PERIOD_EN
        logic [3:0] x;
`endif
        bus.start = 1'b0; bus.a = 4'd5; bus.b = 4'd1; bus.in_valid = 1'b0; bus.in_data = '0;

        // scenario 1: lock on 4th sample; 2: single error; 3: loss + relock; 5: start drop
        add(1,5,1,0, 0,  0,0,0,0,0);
        add(1,5,1,1, 3,  0,0,0,0,0);
        add(1,5,1,1, 0,  1,0,0,0,0);
        add(1,5,1,1, 1,  6,0,0,0,0);
        add(1,5,1,1, 6, 15,1,0,0,0);
        add(1,5,1,1,15, 12,1,0,0,0);
        add(1,5,1,1,12, 13,1,0,0,0);
        add(1,5,1,1, 9,  2,1,1,1,0);
        add(1,5,1,1, 2, 11,1,0,1,0);
        add(1,5,1,1,11,  8,1,0,1,0);
        add(1,5,1,1, 0,  9,1,1,2,0);
        add(1,5,1,1, 0,  1,0,1,3,1);
        add(1,5,1,1,14,  7,0,0,3,1);
        add(1,5,1,1, 7,  4,0,0,3,1);
        add(1,5,1,1, 4,  5,0,0,3,1);
        add(1,5,1,1, 5, 10,1,0,3,1);
        add(0,5,1,1, 0, 10,0,0,3,1);
        add(0,5,1,0, 0, 10,0,0,3,1);
        add(1,5,1,0, 0, 10,0,0,3,1);
        add(1,5,1,1, 3,  0,0,0,3,1);
        add(1,5,1,1, 0,  1,0,0,3,1);
        add(1,5,1,1, 1,  6,0,0,3,1);
        add(1,5,1,1, 6, 15,1,0,3,1);
        // scenario 4: in_valid toggling, idle cycles carry junk data
        add(0,5,1,0, 0, 15,0,0,3,1);
        add(1,5,1,0, 0, 15,0,0,3,1);
        add(1,5,1,1, 3,  0,0,0,3,1);
        add(1,5,1,0, 5,  0,0,0,3,1);
        add(1,5,1,1, 0,  1,0,0,3,1);
        add(1,5,1,0, 7,  1,0,0,3,1);
        add(1,5,1,1, 1,  6,0,0,3,1);
        add(1,5,1,0, 2,  6,0,0,3,1);
        add(1,5,1,1, 6, 15,1,0,3,1);
        add(1,5,1,0, 4, 15,1,0,3,1);
        add(1,5,1,1,15, 12,1,0,3,1);
        // different coefficients a=1, b=2
        add(0,1,2,0, 0, 12,0,0,3,1);
        add(1,1,2,0, 0, 12,0,0,3,1);
        add(1,1,2,1, 3,  5,0,0,3,1);
        add(1,1,2,1, 5,  7,0,0,3,1);
        add(1,1,2,1, 7,  9,0,0,3,1);
        add(1,1,2,1, 9, 11,1,0,3,1);

        #12;
        chk("rst_expected", bus.expected, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_err_pulse", bus.err_pulse, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_lost", bus.lost, 0);
`ifdef LCG_CHK_PERIOD_EN
        chk("rst_period", bus.period, 0);
`endif
        @(posedge clk1); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            bus.a = vt[i].a; bus.b = vt[i].b;
            drive(vt[i].start, vt[i].val, vt[i].data);
            step();
            chk($sformatf("v%0d_expected", i), bus.expected, vt[i].e_exp);
            chk($sformatf("v%0d_locked", i), bus.locked, vt[i].e_lk);
            chk($sformatf("v%0d_err_pulse", i), bus.err_pulse, vt[i].e_pl);
            chk($sformatf("v%0d_err_cnt", i), bus.err_cnt, vt[i].e_cnt);
            chk($sformatf("v%0d_lost", i), bus.lost, vt[i].e_lost);
        end

        // err_cnt saturation: alternate wrong/right keeps lock while errors accumulate
        e = 4'd11; cnt = 8'd3;
        for (int i = 0; i < 260; i++) begin
            drive(1, 1, e ^ 4'd1);
            step();
            e = nf(e, 4'd1, 4'd2);
            cnt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            chk($sformatf("sat%0d_err_cnt", i), bus.err_cnt, cnt);
            chk($sformatf("sat%0d_err_pulse", i), bus.err_pulse, 1);
            drive(1, 1, e);
            step();
            e = nf(e, 4'd1, 4'd2);
        end
        chk("sat_locked", bus.locked, 1);
        chk("sat_final_cnt", bus.err_cnt, 255);

        // asynchronous reset mid-stream, checked before the next clock edge
        drive(1, 1, e);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_expected", bus.expected, 0);
        chk("arst_locked", bus.locked, 0);
        chk("arst_err_cnt", bus.err_cnt, 0);
        chk("arst_lost", bus.lost, 0);
`ifdef LCG_CHK_PERIOD_EN
        chk("arst_period", bus.period, 0);
`endif
        drive(0, 0, 0);
        step();
        rst_n = 1'b1;

`ifdef LCG_CHK_PERIOD_EN
        bus.a = 4'd5; bus.b = 4'd1;
        drive(1, 0, 0);
        step();
        x = 4'd3;
        for (int i = 1; i <= 20; i++) begin
            drive(1, 1, x);
            step();
            x = nf(x, 4'd5, 4'd1);
            if (i == 4)  chk("p16_locked", bus.locked, 1);
            if (i == 19) chk("p16_before", bus.period, 0);
        end
        chk("p16_period", bus.period, 16);

        drive(0, 0, 0);
        step();
        chk("p_hold_idle", bus.period, 16);
        bus.a = 4'd1; bus.b = 4'd2;
        drive(1, 0, 0);
        step();
        x = 4'd3;
        for (int i = 1; i <= 12; i++) begin
            drive(1, 1, x);
            step();
            x = nf(x, 4'd1, 4'd2);
            if (i == 11) chk("p8_before", bus.period, 16);
        end
        chk("p8_period", bus.period, 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
